// File: rtl/constraint_sampler_driver.sv
// Candidate generator for the combinational constraint checker: xorshift64 words
// fill a candidate, the checker's verdict is awaited, rejects retry up to MAX_TRIES.
// Optional macro SAMPLER_STATS_EN adds saturating accept/reject counters.
module constraint_sampler_driver #(
  parameter int          VEC_W     = 64,
  parameter logic [63:0] SEED      = 64'h0000_0000_0000_0001,
  parameter int          MAX_TRIES = 1024,
  parameter int          CHECK_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             seed_load_i,
  input  logic [63:0]      seed_in_i,
  output logic [VEC_W-1:0] cand_o,
  input  logic             chk_sat_i,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic [VEC_W-1:0] sample_o,
  output logic             fail_o,
  output logic [15:0]      tries_o,
  output logic             busy_o
`ifdef SAMPLER_STATS_EN
  ,
  output logic [31:0]      stat_accept_o,
  output logic [31:0]      stat_reject_o
`endif
);

  localparam logic [63:0] SUBST  = 64'h9E37_79B9_7F4A_7C15;
  localparam int          NWORDS = (VEC_W + 63) / 64;
  localparam int          WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(NWORDS - 1);
  localparam logic [2:0]  LLAST  = 3'(CHECK_LAT);
  localparam logic [15:0] TLAST  = 16'(MAX_TRIES - 1);
  localparam logic [15:0] TMAX   = 16'(MAX_TRIES);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  function automatic logic [63:0] fix_seed(input logic [63:0] s);
    return (s == 64'd0) ? SUBST : s;
  endfunction

  function automatic logic [63:0] xs64(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  logic [2:0]       state;
  logic [63:0]      prng;
  logic [VEC_W-1:0] cand;
  logic [15:0]      tries;
  logic [WCW-1:0]   wcnt;
  logic [2:0]       lcnt;
  logic [63:0]      word;
  logic [VEC_W-1:0] cand_nxt;
  logic             verdict;

  assign word    = xs64(prng);
  assign verdict = (state == ST_CHECK) && (lcnt == LLAST);

  // Shift words in from the bottom so the first word lands on top; any bits
  // of it above VEC_W fall off.
  generate
    if (NWORDS == 1) begin : g_one
      assign cand_nxt = word[VEC_W-1:0];
    end else begin : g_multi
      assign cand_nxt = {cand[VEC_W-65:0], word};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      prng  <= fix_seed(SEED);
      cand  <= '0;
      tries <= '0;
      wcnt  <= '0;
      lcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_load_i) begin
            prng <= fix_seed(seed_in_i);
          end else if (run_i) begin
            state <= ST_FILL;
            tries <= '0;
            wcnt  <= '0;
          end
        end
        ST_FILL: begin
          prng <= word;
          cand <= cand_nxt;
          if (wcnt == WLAST) begin
            state <= ST_CHECK;
            wcnt  <= '0;
            lcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (verdict) begin
            if (chk_sat_i) begin
              state <= ST_HOLD;
            end else if (tries == TLAST) begin
              state <= ST_FAIL;
              tries <= TMAX;
            end else begin
              state <= ST_FILL;
              tries <= tries + 16'd1;
            end
          end else begin
            lcnt <= lcnt + 3'd1;
          end
        end
        ST_HOLD: begin
          if (sample_ready_i) begin
            if (run_i) begin
              state <= ST_FILL;
              tries <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_FAIL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cand_o         = cand;
  assign sample_o       = cand;
  assign tries_o        = tries;
  assign sample_valid_o = (state == ST_HOLD);
  assign fail_o         = (state == ST_FAIL);
  assign busy_o         = (state != ST_IDLE);

`ifdef SAMPLER_STATS_EN
  logic [31:0] acc_cnt, rej_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (sample_valid_o && sample_ready_i && acc_cnt != 32'hFFFF_FFFF)
        acc_cnt <= acc_cnt + 32'd1;
      if (verdict && !chk_sat_i && rej_cnt != 32'hFFFF_FFFF)
        rej_cnt <= rej_cnt + 32'd1;
    end
  end

  assign stat_accept_o = acc_cnt;
  assign stat_reject_o = rej_cnt;
`endif

endmodule

// File: tb/tb_constraint_sampler_driver.sv
// Directed bench for constraint_sampler_driver: three instances cover the
// 64-bit, small-budget and 100-bit/latency configurations.
module tb_constraint_sampler_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // A: VEC_W=64, SEED=1, MAX_TRIES=8, CHECK_LAT=0
  logic a_run, a_sl, a_sat, a_rdy, a_valid, a_fail, a_busy;
  logic [63:0] a_seed, a_cand, a_sample;
  logic [15:0] a_tries;
  // B: MAX_TRIES=4
  logic b_run, b_sl, b_sat, b_rdy, b_valid, b_fail, b_busy;
  logic [63:0] b_seed, b_cand, b_sample;
  logic [15:0] b_tries;
  // C: VEC_W=100, CHECK_LAT=2
  logic c_run, c_sl, c_sat, c_rdy, c_valid, c_fail, c_busy;
  logic [63:0] c_seed;
  logic [99:0] c_cand, c_sample;
  logic [15:0] c_tries;
`ifdef SAMPLER_STATS_EN
  logic [31:0] a_sa, a_sr, b_sa, b_sr, c_sa, c_sr;
`endif

  constraint_sampler_driver #(.VEC_W(64), .SEED(64'd1), .MAX_TRIES(8), .CHECK_LAT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .run_i(a_run), .seed_load_i(a_sl), .seed_in_i(a_seed),
    .cand_o(a_cand), .chk_sat_i(a_sat), .sample_valid_o(a_valid), .sample_ready_i(a_rdy),
    .sample_o(a_sample), .fail_o(a_fail), .tries_o(a_tries), .busy_o(a_busy)
`ifdef SAMPLER_STATS_EN
    , .stat_accept_o(a_sa), .stat_reject_o(a_sr)
`endif
  );

  constraint_sampler_driver #(.VEC_W(64), .SEED(64'd1), .MAX_TRIES(4), .CHECK_LAT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .run_i(b_run), .seed_load_i(b_sl), .seed_in_i(b_seed),
    .cand_o(b_cand), .chk_sat_i(b_sat), .sample_valid_o(b_valid), .sample_ready_i(b_rdy),
    .sample_o(b_sample), .fail_o(b_fail), .tries_o(b_tries), .busy_o(b_busy)
`ifdef SAMPLER_STATS_EN
    , .stat_accept_o(b_sa), .stat_reject_o(b_sr)
`endif
  );

  constraint_sampler_driver #(.VEC_W(100), .SEED(64'd1), .MAX_TRIES(4), .CHECK_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .run_i(c_run), .seed_load_i(c_sl), .seed_in_i(c_seed),
    .cand_o(c_cand), .chk_sat_i(c_sat), .sample_valid_o(c_valid), .sample_ready_i(c_rdy),
    .sample_o(c_sample), .fail_o(c_fail), .tries_o(c_tries), .busy_o(c_busy)
`ifdef SAMPLER_STATS_EN
    , .stat_accept_o(c_sa), .stat_reject_o(c_sr)
`endif
  );

  int checks = 0;
  int errors = 0;
  int a_xfer = 0;
  int b_fails = 0;

  always @(posedge clk) begin
    if (a_valid && a_rdy) a_xfer <= a_xfer + 1;
    if (b_fail) b_fails <= b_fails + 1;
  end

  function automatic logic [63:0] xs(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] w [0:8];
  logic [63:0] v1, v2, v3, v4;
  logic [99:0] c_exp;
  int x0, f0;

  initial begin
    rst_n = 1'b0;
    a_run = 0; a_sl = 0; a_sat = 0; a_rdy = 0; a_seed = '0;
    b_run = 0; b_sl = 0; b_sat = 0; b_rdy = 0; b_seed = '0;
    c_run = 0; c_sl = 0; c_sat = 0; c_rdy = 0; c_seed = '0;
    w[0] = 64'd1;
    for (int k = 1; k <= 8; k++) w[k] = xs(w[k-1]);
    v1 = xs(64'h9E37_79B9_7F4A_7C15);
    v2 = xs(v1);
    v3 = xs(v2);
    v4 = xs(v3);

    tick(); tick();
    chk("rst_cand", a_cand, 0);
    chk("rst_tries", a_tries, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_cand_c", c_cand, 0);

    // Always-satisfied checker, always-ready consumer
    rst_n = 1'b1;
    a_sat = 1; a_rdy = 1; a_run = 1;
    tick(); chk("t1_busy", a_busy, 1); chk("t1_v_fill", a_valid, 0);
    tick(); chk("t1_cand", a_cand, 64'h0000_0000_4082_2041); chk("t1_v_chk", a_valid, 0);
    tick(); chk("t1_valid", a_valid, 1); chk("t1_sample", a_sample, 64'h0000_0000_4082_2041);
    tick(); chk("t1_v_fill2", a_valid, 0);
    tick(); chk("t1_v_chk2", a_valid, 0); chk("t1_cand2", a_cand, w[2]);
    tick(); chk("t1_valid2", a_valid, 1); chk("t1_sample2", a_sample, w[2]);

    // Five rejects then accept
    a_run = 0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; a_sat = 0; a_rdy = 0; a_run = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_tries", a_tries, k);
      chk("t2_cand", a_cand, w[k+1]);
      tick();
      chk("t2_fail", a_fail, 0);
    end
    a_sat = 1;
    tick(); chk("t2_tries5", a_tries, 5); chk("t2_cand6", a_cand, w[6]);
    tick(); chk("t2_valid", a_valid, 1); chk("t2_sample", a_sample, w[6]); chk("t2_fail_acc", a_fail, 0);

    // Backpressure in HOLD
    x0 = a_xfer;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_valid", a_valid, 1);
      chk("t4_sample", a_sample, w[6]);
    end
    chk("t4_noxfer", a_xfer - x0, 0);
    a_rdy = 1;
    tick(); chk("t4_v_drop", a_valid, 0); chk("t4_xfer1", a_xfer - x0, 1); chk("t4_tries0", a_tries, 0);
    tick(); chk("t4_next_cand", a_cand, w[7]);
    tick(); chk("t4_next_valid", a_valid, 1); chk("t4_next_sample", a_sample, w[7]);
    a_run = 0;
    tick(); chk("t4_idle_busy", a_busy, 0); chk("t4_idle_valid", a_valid, 0);

    // Reset during CHECK, then during HOLD
    a_run = 1; a_rdy = 0;
    tick(); tick(); chk("t6_in_check", a_busy, 1); chk("t6_chk_valid", a_valid, 0);
    rst_n = 1'b0;
    tick();
    chk("t6_c_cand", a_cand, 0); chk("t6_c_tries", a_tries, 0); chk("t6_c_valid", a_valid, 0);
    chk("t6_c_fail", a_fail, 0); chk("t6_c_busy", a_busy, 0);
    rst_n = 1'b1;
    tick(); tick(); chk("t6_restart_cand", a_cand, 64'h0000_0000_4082_2041);
    tick(); chk("t6_hold_valid", a_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_h_valid", a_valid, 0); chk("t6_h_busy", a_busy, 0); chk("t6_h_sample", a_sample, 0);
    rst_n = 1'b1; a_rdy = 1;
    tick(); tick(); tick();
    chk("t6_h_restart_valid", a_valid, 1); chk("t6_h_restart_sample", a_sample, 64'h0000_0000_4082_2041);
    a_run = 0;
    tick();

    // Never-satisfied checker, budget of 4
    f0 = b_fails;
    b_sat = 0; b_rdy = 1; b_run = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_tries", b_tries, k);
      chk("t3_nofail", b_fail, 0);
      tick();
    end
    chk("t3_fail", b_fail, 1); chk("t3_fail_tries", b_tries, 4); chk("t3_fail_busy", b_busy, 1);
    tick(); chk("t3_idle_fail", b_fail, 0); chk("t3_idle_busy", b_busy, 0); chk("t3_one_pulse", b_fails - f0, 1);
    tick(); chk("t3_restart_busy", b_busy, 1); chk("t3_restart_tries", b_tries, 0);
    tick(); chk("t3_restart_cand", b_cand, w[5]);
    b_run = 0;

    // 100-bit vector, CHECK_LAT=2, zero seed substituted
    c_sl = 1; c_seed = 64'd0;
    tick();
    c_sl = 0; c_run = 1; c_sat = 1; c_rdy = 0;
    tick(); chk("t5_busy", c_busy, 1);
    tick(); chk("t5_fill2_valid", c_valid, 0);
    c_sat = 0;
    c_exp = {v1[35:0], v2};
    tick(); chk("t5_cand", c_cand, c_exp);
    tick(); chk("t5_lat1", c_valid, 0);
    tick(); chk("t5_lat2", c_valid, 0); chk("t5_lat2_tries", c_tries, 0);
    c_sat = 1;
    tick(); chk("t5_valid", c_valid, 1); chk("t5_sample", c_sample, c_exp); chk("t5_tries", c_tries, 0);
    c_sl = 1; c_seed = 64'h1234;
    tick(); chk("t5_hold_sl", c_valid, 1);
    c_sl = 0; c_rdy = 1; c_run = 0;
    tick(); chk("t5_idle", c_busy, 0);
    c_run = 1;
    c_exp = {v3[35:0], v4};
    tick(); tick(); tick(); chk("t5_cand2", c_cand, c_exp);
    c_run = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
